// File: rtl/bt656_key_line_gate_pkg.sv
// Shared BT.656 definitions for the key-line gate: TRS words, XYZ bit map, TRS parser states.
// Latency: n/a (types and constants only); backpressure: n/a.
package bt656_pkg;

  typedef logic [9:0] word_t;

  localparam word_t TRS_ONES  = 10'h3FF;
  localparam word_t TRS_ZEROS = 10'h000;

  localparam int XYZ_ONE = 9;
  localparam int XYZ_F   = 8;
  localparam int XYZ_V   = 7;
  localparam int XYZ_H   = 6;
  localparam int XYZ_P3  = 5;
  localparam int XYZ_P2  = 4;
  localparam int XYZ_P1  = 3;
  localparam int XYZ_P0  = 2;

  localparam logic [9:0] LINE_MAX = 10'd1023;

  typedef enum logic [1:0] {
    TRS_IDLE,
    TRS_S1,
    TRS_S2,
    TRS_S3
  } trs_state_t;

  // Expected P3..P0 for a given F/V/H triple.
  function automatic logic [3:0] xyz_protection(input logic f, input logic v, input logic h);
    return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

endpackage

// File: rtl/bt656_key_line_gate_if.sv
// Word-stream bundle between the decoder capture path, the key-line gate and the sequence detector.
// Latency: n/a (wiring only); backpressure: none, one word per clock.
interface bt656_key_line_gate_if;
  import bt656_pkg::*;

  word_t      video_in;
  word_t      sequence_out;
  logic       enable_out;
  logic       field_out;
  logic [9:0] line_out;
  logic       locked_out;
  logic       trs_error_out;

  modport master (
    output video_in,
    input  sequence_out,
    input  enable_out,
    input  field_out,
    input  line_out,
    input  locked_out,
    input  trs_error_out
  );

  modport slave (
    input  video_in,
    output sequence_out,
    output enable_out,
    output field_out,
    output line_out,
    output locked_out,
    output trs_error_out
  );

endinterface

// File: rtl/bt656_key_line_gate_trs_decoder.sv
// TRS parser: finds 3FF-000-000-XYZ and decodes F/V/H; P3..P0 checked when BT656_TRS_PROTECTION_CHECK_EN is defined.
// Latency: flags are combinational on the XYZ word; backpressure: none, one word per clock.
module bt656_trs_decoder
  import bt656_pkg::*;
(
  input  logic  clock,
  input  logic  reset_n,
  input  word_t video,
  output logic  xyz_valid,
  output logic  xyz_error,
  output logic  f,
  output logic  v,
  output logic  h,
  output logic  trs_start
);

  trs_state_t state_q;
  trs_state_t state_d;
  logic       prot_ok;

`ifdef BT656_TRS_PROTECTION_CHECK_EN
  assign prot_ok = (video[XYZ_P3:XYZ_P0] ==
                    xyz_protection(video[XYZ_F], video[XYZ_V], video[XYZ_H]));
`else
  assign prot_ok = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= TRS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    xyz_valid = 1'b0;
    xyz_error = 1'b0;
    case (state_q)
      TRS_IDLE: begin
        if (video == TRS_ONES) state_d = TRS_S1;
      end
      TRS_S1: begin
        if (video == TRS_ZEROS)     state_d = TRS_S2;
        else if (video == TRS_ONES) state_d = TRS_S1;
        else                        state_d = TRS_IDLE;
      end
      TRS_S2: begin
        if (video == TRS_ZEROS)     state_d = TRS_S3;
        else if (video == TRS_ONES) state_d = TRS_S1;
        else                        state_d = TRS_IDLE;
      end
      TRS_S3: begin
        // The XYZ word itself may be 3FF, which restarts the preamble.
        state_d = (video == TRS_ONES) ? TRS_S1 : TRS_IDLE;
        if (video[XYZ_ONE] && prot_ok) xyz_valid = 1'b1;
        else                           xyz_error = 1'b1;
      end
      default: state_d = TRS_IDLE;
    endcase
  end

  assign f         = video[XYZ_F];
  assign v         = video[XYZ_V];
  assign h         = video[XYZ_H];
  assign trs_start = (video == TRS_ONES);

endmodule

// File: rtl/bt656_key_line_gate.sv
// Key-line gate: tracks field/line from EAV and forwards one word window of the key line (XYZ protection under BT656_TRS_PROTECTION_CHECK_EN).
// Latency: 1 clock video_in->sequence_out, enable_out aligned; backpressure: none, one word per clock.
module bt656_key_line_gate
  import bt656_pkg::*;
#(
  parameter int KEY_LINE     = 10,
  parameter int KEY_FIELD    = 2,
  parameter int SAMPLE_START = 16,
  parameter int SAMPLE_COUNT = 64
) (
  input logic                  clock,
  input logic                  reset_n,
  bt656_key_line_gate_if.slave bus
);

  localparam logic [9:0]  KEY_LINE_W = 10'(KEY_LINE);
  localparam logic [10:0] WIN_FIRST  = 11'(SAMPLE_START);
  localparam logic [10:0] WIN_LAST   = 11'(SAMPLE_START + SAMPLE_COUNT - 1);
  localparam bit          ANY_FIELD  = (KEY_FIELD == 2);
  localparam logic        KEY_F      = (KEY_FIELD == 1);

  logic        xyz_valid;
  logic        xyz_error;
  logic        xyz_f;
  logic        xyz_v;
  logic        xyz_h;
  logic        trs_start;
  logic        unused_xyz_v;

  word_t       seq_q;
  logic        en_q;
  logic        field_q;
  logic [9:0]  line_q;
  logic        locked_q;
  logic        err_q;
  logic        armed_q;
  logic [10:0] cnt_q;

  logic        arm_ok;
  logic        in_window;

  bt656_trs_decoder u_trs (
    .clock     (clock),
    .reset_n   (reset_n),
    .video     (bus.video_in),
    .xyz_valid (xyz_valid),
    .xyz_error (xyz_error),
    .f         (xyz_f),
    .v         (xyz_v),
    .h         (xyz_h),
    .trs_start (trs_start)
  );

  // V plays no part in picking the key line: active and VBI lines are told apart by line index.
  assign unused_xyz_v = xyz_v;

  // Field/line tracking; a change of F marks the field boundary.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      field_q  <= 1'b0;
      line_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= xyz_error;
      if (xyz_valid && xyz_h) begin
        if (xyz_f != field_q) begin
          line_q   <= '0;
          field_q  <= xyz_f;
          locked_q <= 1'b1;
        end else if (line_q != LINE_MAX) begin
          line_q <= line_q + 10'd1;
        end
      end
    end
  end

  assign arm_ok    = locked_q && (line_q == KEY_LINE_W) && (ANY_FIELD || (field_q == KEY_F));
  assign in_window = (cnt_q >= WIN_FIRST) && (cnt_q <= WIN_LAST);

  // Window counter runs from the word after SAV XYZ; any 3FF closes the window before it is qualified.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seq_q   <= '0;
      en_q    <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      seq_q <= bus.video_in;
      en_q  <= 1'b0;
      if (xyz_valid && !xyz_h) begin
        armed_q <= arm_ok;
        cnt_q   <= '0;
      end else if (armed_q) begin
        en_q  <= in_window && !trs_start;
        cnt_q <= cnt_q + 11'd1;
        if (trs_start || (cnt_q == WIN_LAST)) armed_q <= 1'b0;
      end
    end
  end

  assign bus.sequence_out  = seq_q;
  assign bus.enable_out    = en_q;
  assign bus.field_out     = field_q;
  assign bus.line_out      = line_q;
  assign bus.locked_out    = locked_q;
  assign bus.trs_error_out = err_q;

endmodule

// File: doc/bt656_key_line_gate.md
# bt656_key_line_gate

Front-end stage of the TVP5147M1 decoder interface, placed directly upstream of the sequence detector. It parses the decoder's 10-bit BT.656 stream and decodes the timing reference codes (EAV/SAV). It tracks field and line number, and forwards one configured window of one configured VBI line as `sequence_out` qualified by `enable_out`. Its outputs drive the detector's `sequence_in` and `enable_in`. `enable_out` falls between lines, so the detector's shift register and trigger are cleared for every key line.

## Interface
- `KEY_LINE`, 10: line index within the field, counted from 0 at the field boundary, that carries the key sequence.
- `KEY_FIELD`, 2: field select. 0 selects F=0 only, 1 selects F=1 only, 2 selects both fields.
- `SAMPLE_START`, 16: word offset after the SAV XYZ word where the window opens. Must be even so the window starts on a Cb word.
- `SAMPLE_COUNT`, 64: number of words in the window. Range 1..1440.

Ports:
- `clock` in 1: 27 MHz word clock, one BT.656 word per rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `video_in` in 10: BT.656 word from the TVP5147M1.
- `sequence_out` out 10: registered copy of `video_in`.
- `enable_out` out 1: high while `sequence_out` holds a window word.
- `field_out` out 1: F bit of the last accepted EAV.
- `line_out` out 10: current line index within the field.
- `locked_out` out 1: set once a field boundary has been seen since reset.
- `trs_error_out` out 1: one-cycle pulse on a malformed or protection-failing XYZ word.

## Operation
- TRS FSM states and transitions:
  - IDLE: on 3FF go to S1.
  - S1: on 000 go to S2; on 3FF stay in S1; otherwise go to IDLE.
  - S2: on 000 go to S3; on 3FF go to S1; otherwise go to IDLE.
  - S3: the current word is XYZ; next state is S1 if the word is 3FF, else IDLE.
- XYZ decode: bit9 must be 1. F=bit8, V=bit7, H=bit6, P3..P0=bits5:2.
- Protection: P3=V^H, P2=F^H, P1=F^V, P0=F^V^H.
- A rejected XYZ word pulses `trs_error_out` and has no other effect. A word is rejected if bit9=0, or if protection fails (check only when the macro is enabled).
- Accepted EAV (H=1):
  - If F differs from the stored F: `line_out` is cleared to 0, F is stored, and `locked_out` is set.
  - Otherwise `line_out` increments, saturating at 1023.
- Accepted SAV (H=0): the window is armed only if all of the following hold:
  - `locked_out` is high;
  - `line_out` equals `KEY_LINE`;
  - the stored F matches `KEY_FIELD`, or `KEY_FIELD`=2.
- Armed window:
  - An 11-bit word counter starts at 0 on the word after XYZ.
  - Gated words are those with counter in [`SAMPLE_START`, `SAMPLE_START`+`SAMPLE_COUNT`-1].
  - The window disarms after its last word, or immediately when `video_in`=3FF (an early TRS aborts the window).
- Reset values: all outputs 0, FSM in IDLE, stored F=0, window disarmed, counter 0.
- Reset mid-line drops any open window. No window can open until a new field boundary sets `locked_out`.

## Timing
- Latency from `video_in` to `sequence_out` is 1 clock. `enable_out` is registered and aligned with `sequence_out`.
- XYZ sampled at edge t:
  - `line_out`, `field_out`, `locked_out`, and the `trs_error_out` pulse update at edge t.
  - The first gated word is sampled at edge t+1+`SAMPLE_START` and appears with `enable_out`=1 after that edge.
- `enable_out` stays high for exactly `SAMPLE_COUNT` consecutive cycles, unless aborted.
- Abort: when 3FF is sampled at edge k, `enable_out` is 0 after edge k, so the 3FF word is never qualified.
- `enable_out` is low for at least the whole EAV/blanking interval between two key lines.
- Simultaneous events:
  - A field-change EAV on the key line still clears `line_out`; the SAV then compares against 0.
  - If `KEY_LINE`=0, the window opens on the first line after the boundary.

## Configuration
- `BT656_TRS_PROTECTION_CHECK_EN`:
  - Defined: P3..P0 are checked, failing XYZ words are ignored, and `trs_error_out` pulses.
  - Undefined: any XYZ word with bit9=1 is accepted, and `trs_error_out` pulses only for bit9=0.

## Structure
- Package `bt656_pkg`:
  - TRS word constants 10'h3FF and 10'h000;
  - XYZ bit indices for F, V, H, and P3..P0;
  - the TRS FSM state enum;
  - the line-counter saturation value.
- Sub-module `bt656_trs_decoder`:
  - contains the FSM and the protection check;
  - outputs `xyz_valid`, `xyz_error`, F, V, H, and `trs_start` (3FF seen).
- The top level holds the line counter, the field/lock registers, the window counter, and the output registers.

## Test plan
- Reset, then two fields of valid EAV/SAV with F toggling -> `locked_out`=1 at the first F change; `line_out` counts 0,1,2… per EAV.
- `KEY_LINE`=10, `KEY_FIELD`=2, `SAMPLE_START`=16, `SAMPLE_COUNT`=64, ramp data on line 10 -> `enable_out` high for exactly 64 cycles; first `sequence_out` is the 17th word after SAV XYZ, data in order; no enable on other lines.
- `KEY_FIELD`=0 -> window appears only in F=0 fields; the F=1 key line produces no enable.
- XYZ with a flipped P0 on the key-line SAV, macro defined -> `trs_error_out` one-cycle pulse, no window; macro undefined -> window opens.
- 3FF injected at window word 20 -> `enable_out` drops after that edge, 3FF never qualified; the next line behaves normally.
- `reset_n` asserted mid-window -> all outputs 0 asynchronously; after release, no window until the next F change.
